// File: rtl/nibble_arith_pipe_if.sv
// ============================================================================
//  Module   : nibble_arith_pipe_if
//  Brief    : Operand/result valid-ready bundle for nibble_arith_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_arith_pipe_if #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 carry;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry
    );
endinterface

`default_nettype wire

// File: rtl/nibble_arith_pipe.sv
// ============================================================================
//  Module   : nibble_arith_pipe
//  Brief    : Two-stage valid/ready pipelined ADD/SUB/ACC/CLR unit with a
//             widened result and carry/borrow flag. Define NIBBLE_ARITH_SAT_EN
//             for saturating instead of wrapping arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_arith_pipe #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    nibble_arith_pipe_if.slave s_if
);

    localparam int EXT = ACC_WIDTH + 1;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_ACC = 2'b10;
    localparam logic [1:0] c_OP_CLR = 2'b11;

    logic                 r_s1_valid;
    logic [1:0]           r_s1_op;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic                 r_s2_valid;
    logic [ACC_WIDTH-1:0] r_result;
    logic                 r_carry;
    logic [ACC_WIDTH-1:0] r_acc;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [EXT-1:0]       w_a_ext;
    logic [EXT-1:0]       w_b_ext;
    logic [EXT-1:0]       w_sum;
    logic [EXT-1:0]       w_diff;
    logic [EXT-1:0]       w_acc_sum;
    logic [ACC_WIDTH-1:0] w_res;
    logic                 w_carry;

    assign w_s2_adv   = !r_s2_valid || s_if.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_in_ready = !reset && (!r_s1_valid || w_s2_adv);
    assign w_accept   = s_if.in_valid && w_in_ready;

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = r_s2_valid;
    assign s_if.result    = r_result;
    assign s_if.carry     = r_carry;

    // One extra bit of headroom: its value is the carry, or the borrow for SUB.
    assign w_a_ext   = EXT'(r_s1_a);
    assign w_b_ext   = EXT'(r_s1_b);
    assign w_sum     = w_a_ext + w_b_ext;
    assign w_diff    = w_a_ext - w_b_ext;
    assign w_acc_sum = EXT'(r_acc) + w_a_ext + w_b_ext;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (r_s1_op)
            c_OP_ADD: begin
                w_res   = w_sum[ACC_WIDTH-1:0];
                w_carry = w_sum[ACC_WIDTH];
            end
            c_OP_SUB: begin
                w_res   = w_diff[ACC_WIDTH-1:0];
                w_carry = w_diff[ACC_WIDTH];
            end
            c_OP_ACC: begin
                w_res   = w_acc_sum[ACC_WIDTH-1:0];
                w_carry = w_acc_sum[ACC_WIDTH];
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
`ifdef NIBBLE_ARITH_SAT_EN
        if (w_carry) begin
            w_res = (r_s1_op == c_OP_SUB) ? '0 : '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= s_if.op;
                r_s1_a     <= s_if.a;
                r_s1_b     <= s_if.b;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_result   <= w_res;
                r_carry    <= w_carry;
                // CLR yields w_res == 0, so both ACC and CLR load the result.
                if (r_s1_op == c_OP_ACC || r_s1_op == c_OP_CLR) begin
                    r_acc <= w_res;
                end
            end else if (s_if.out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_arith_pipe.sv
// ============================================================================
//  Module   : tb_nibble_arith_pipe
//  Brief    : Scoreboard bench for nibble_arith_pipe (directed vectors plus a
//             short pseudo-random stream against a reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_arith_pipe;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nibble_arith_pipe_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    nibble_arith_pipe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .s_if  (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         n_acc       = 0;
    int         m_acc       = 0;
    bit         rnd_ready   = 1'b0;
    logic [8:0] sb[$];
    logic [8:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wrapping (or saturating) reference arithmetic on plain integers.
    function automatic logic [8:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int         s;
        logic       c;
        logic [7:0] r;
        case (op)
            2'd0:    s = int'(a) + int'(b);
            2'd1:    s = int'(a) - int'(b);
            2'd2:    s = m_acc + int'(a) + int'(b);
            default: s = 0;
        endcase
        c = (s > 255) || (s < 0);
`ifdef NIBBLE_ARITH_SAT_EN
        r = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
`else
        r = 8'(s);
`endif
        if (op == 2'd2) m_acc = int'(r);
        if (op == 2'd3) m_acc = 0;
        return {c, r};
    endfunction

    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] er, input logic ec);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        forever begin
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sb.push_back({ec, er});
        n_acc++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {23'd0, bus.carry, bus.result}, 32'h1ff);
            end else begin
                mon_exp = sb.pop_front();
                chk("result_carry", {23'd0, bus.carry, bus.result}, {23'd0, mon_exp});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [1:0] rop;
        logic [3:0] ra, rb;
        logic [8:0] e;

        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.a         = 4'd0;
        bus.b         = 4'd0;
        bus.out_ready = 1'b1;

        #12;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result",    bus.result,    0);
        chk("reset_carry",     bus.carry,     0);
        chk("reset_in_ready",  bus.in_ready,  0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD 9+8; out_valid rises on the second edge counting the accept edge.
        send(2'd0, 4'd9, 4'd8, 8'h11, 1'b0);
        chk("latency_stage1_only", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", bus.out_valid, 1);
        drain();

`ifdef NIBBLE_ARITH_SAT_EN
        send(2'd1, 4'd3, 4'd5, 8'h00, 1'b1);
`else
        send(2'd1, 4'd3, 4'd5, 8'hFE, 1'b1);
`endif
        drain();

        send(2'd3, 4'd7, 4'd7, 8'd0, 1'b0);
        for (int k = 1; k <= 8; k++) send(2'd2, 4'd15, 4'd15, 8'(30 * k), 1'b0);
`ifdef NIBBLE_ARITH_SAT_EN
        send(2'd2, 4'd15, 4'd15, 8'd255, 1'b1);
`else
        send(2'd2, 4'd15, 4'd15, 8'd14, 1'b1);
`endif
        drain();

        // Backpressure: three beats offered while the sink stalls.
        bus.out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send(2'd0, 4'd1, 4'd2, 8'd3, 1'b0);
                send(2'd1, 4'd7, 4'd2, 8'd5, 1'b0);
                send(2'd0, 4'd15, 4'd15, 8'd30, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_accepts",   n_acc - base,  2);
                chk("stall_in_ready",  bus.in_ready,  0);
                chk("stall_out_valid", bus.out_valid, 1);
                chk("stall_result",    bus.result,    3);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages holding a beat.
        bus.out_ready = 1'b0;
        send(2'd0, 4'd1, 4'd1, 8'd2, 1'b0);
        send(2'd0, 4'd2, 4'd2, 8'd4, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_result",    bus.result,    0);
        chk("midreset_in_ready",  bus.in_ready,  0);
        sb.delete();
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        send(2'd2, 4'd1, 4'd1, 8'd2, 1'b0);
        drain();

        // Pseudo-random stream with a randomly stalling sink.
        m_acc = 2;
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            e   = model(rop, ra, rb);
            send(rop, ra, rb, e[7:0], e[8]);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
